conv_stream_host: RTL and testbench
===================================

Name: conv_stream_host

Overview:
Stream-side counterpart of the conv_* convolution blocks. It holds one input vector of LENX samples, loaded through a simple write port, and drives it into a conv block's s_data_in_x/s_valid_x/s_ready_x port. It also acts as the sink for the block's m_data_out_y/m_valid_y/m_ready_y stream, capturing LENY results into a buffer that can be read back. It sits between a host/loader and any conv_<LENX>_<LENF>_... instance.

Parameters:
WIDTH, 16, sample width (signed, two's complement)
LENX, 16, input vector length
LENF, 4, filter length of the attached conv block
ADDRX, 4, clog2(LENX)
LENY, LENX-LENF+1 (13), number of expected results
ADDRY, 4, clog2(LENY)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
load_en  in  1  write enable for x buffer
load_addr  in  ADDRX  x buffer write address
load_data  in  WIDTH  x buffer write data
start  in  1  single-cycle pulse, begins one transfer run
busy  out  1  high while in RUN
done  out  1  sticky, high after run completes until next start
m_data_out_x  out  WIDTH  sample to conv s_data_in_x
m_valid_x  out  1  to conv s_valid_x
m_ready_x  in  1  from conv s_ready_x
s_data_in_y  in  WIDTH  from conv m_data_out_y
s_valid_y  in  1  from conv m_valid_y
s_ready_y  out  1  to conv m_ready_y
rd_addr  in  ADDRY  y buffer read address
rd_data  out  WIDTH  y buffer read data, registered

Behaviour:
- Reset is asynchronous and active-high. On reset: state=IDLE; tx_cnt=0, rx_cnt=0; busy=0, done=0, m_valid_x=0, s_ready_y=0, rd_data=0. Buffer contents are not reset.
- FSM states are IDLE, RUN, DONE. IDLE/DONE -> RUN on start=1. RUN -> DONE when tx_cnt==LENX and rx_cnt==LENY. No other transitions.
- Entering RUN clears tx_cnt, rx_cnt and done. busy=1 only in RUN. done=1 only in DONE.
- Latency: start sampled at edge k, so m_valid_x=1 in the cycle after edge k.
- TX side:
  - m_valid_x = (state==RUN && tx_cnt<LENX).
  - m_data_out_x = xbuf[tx_cnt].
  - A transfer occurs on m_valid_x & m_ready_x, and increments tx_cnt.
  - While valid=1 and ready=0, data and valid hold stable (AXI-style). Valid is never withdrawn before the transfer.
- RX side:
  - s_ready_y = (state==RUN && rx_cnt<LENY).
  - On s_valid_y & s_ready_y: ybuf[rx_cnt] <= s_data_in_y, rx_cnt++.
  - TX and RX run concurrently. A y transfer is accepted even if tx_cnt<LENX.
- DONE: asserted in the cycle after the edge that completes the last of both counts. If the final TX and final RX transfers happen in the same cycle, done still rises exactly one cycle later.
- Load port: load_en writes xbuf[load_addr] in IDLE or DONE. It is ignored in RUN.
- Read port: rd_data <= ybuf[rd_addr] every edge, with 1-cycle latency, in any state. During RUN it may return stale entries. rd_addr >= LENY returns an undefined value.
- Stray inputs:
  - start while in RUN is ignored.
  - s_valid_y while s_ready_y=0 (IDLE, DONE, or rx_cnt==LENY) is dropped, and the buffer is unchanged.
- Reset asserted mid-run aborts immediately: state goes to IDLE and both handshake outputs go low asynchronously. xbuf and ybuf keep their contents.
- Counters are ADDRX+1 and ADDRY+1 bits wide so they can reach LENX/LENY without wrapping.

Test Plan:
1. Basic run: load xbuf[i]=i+1 for i=0..15; pulse start; m_ready_x=1 constantly. Required: m_data_out_x = 1..16 on 16 consecutive cycles starting the cycle after start, then m_valid_x=0. Then drive y=100..112, one per cycle. Required: done=1 the cycle after y=112; rd_addr=0 -> 100 and rd_addr=12 -> 112 one cycle later.
2. Backpressure: m_ready_x alternating 1/0 and s_valid_y gaps. Required: m_data_out_x is held stable while ready=0; all 16 x values and 13 y values transfer exactly once; done arrives only after both counts complete.
3. Concurrent completion: final x transfer and 13th y transfer in the same cycle. Required: busy falls and done rises on the next cycle.
4. Ignored inputs: during RUN, pulse start and write load_addr=3, load_data=999. Required: the run is unaffected and xbuf[3] is unchanged (verified on a second run). A 14th s_valid_y after completion is not accepted (s_ready_y=0).
5. Reset mid-run: assert reset after 5 x transfers. Required: m_valid_x=0, s_ready_y=0, busy=0, done=0 immediately. After a subsequent start, x restarts from xbuf[0].
6. Rerun from DONE: start again with new y values 200..212. Required: done clears the cycle after start and ybuf is overwritten.

Source files
------------

// File: rtl/conv_stream_host.sv
// conv_stream_host: streams a loaded x vector into a conv block and captures its LENY results.
// TX and RX handshakes run concurrently; the run ends once both counts are complete.
module conv_stream_host #(
    parameter int WIDTH = 16,
    parameter int LENX  = 16,
    parameter int LENF  = 4,
    parameter int ADDRX = 4,
    parameter int LENY  = LENX - LENF + 1,
    parameter int ADDRY = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [ADDRX-1:0] load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] m_data_out_x,
    output logic             m_valid_x,
    input  logic             m_ready_x,
    input  logic [WIDTH-1:0] s_data_in_y,
    input  logic             s_valid_y,
    output logic             s_ready_y,
    input  logic [ADDRY-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    localparam logic [ADDRX:0] XEND = (ADDRX+1)'(LENX);
    localparam logic [ADDRY:0] YEND = (ADDRY+1)'(LENY);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [ADDRX:0]   tx_cnt_q, tx_cnt_d;
    logic [ADDRY:0]   rx_cnt_q, rx_cnt_d;
    logic [WIDTH-1:0] xbuf_q [2**ADDRX];
    logic [WIDTH-1:0] ybuf_q [2**ADDRY];
    logic [WIDTH-1:0] rd_data_q;
    logic             tx_fire, rx_fire;

    // Handshake outputs decode straight from state so an async reset drops them at once
    assign busy         = state_q == RUN;
    assign done         = state_q == DONE;
    assign m_valid_x    = busy && tx_cnt_q < XEND;
    assign s_ready_y    = busy && rx_cnt_q < YEND;
    assign m_data_out_x = xbuf_q[tx_cnt_q[ADDRX-1:0]];
    assign rd_data      = rd_data_q;
    assign tx_fire      = m_valid_x && m_ready_x;
    assign rx_fire      = s_valid_y && s_ready_y;

    always_comb begin
        state_d  = state_q;
        tx_cnt_d = tx_cnt_q + {{ADDRX{1'b0}}, tx_fire};
        rx_cnt_d = rx_cnt_q + {{ADDRY{1'b0}}, rx_fire};
        if (state_q != RUN && start) begin
            state_d  = RUN;
            tx_cnt_d = '0;
            rx_cnt_d = '0;
        end else if (busy && tx_cnt_d == XEND && rx_cnt_d == YEND) begin
            state_d = DONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            rd_data_q <= ybuf_q[rd_addr];
        end
    end

    // Buffer contents survive reset
    always_ff @(posedge clk) begin
        if (load_en && !busy)
            xbuf_q[load_addr] <= load_data;
        if (rx_fire)
            ybuf_q[rx_cnt_q[ADDRY-1:0]] <= s_data_in_y;
    end
endmodule

// File: tb/tb_conv_stream_host.sv
// tb_conv_stream_host: directed runs with a queue scoreboard for x beats and y readback.
module tb_conv_stream_host;
    logic        clk = 1'b0;
    logic        reset, load_en, start, m_ready_x, s_valid_y;
    logic [3:0]  load_addr, rd_addr;
    logic [15:0] load_data, s_data_in_y;
    logic        busy, done, m_valid_x, s_ready_y;
    logic [15:0] m_data_out_x, rd_data;

    conv_stream_host dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .busy(busy), .done(done),
        .m_data_out_x(m_data_out_x), .m_valid_x(m_valid_x), .m_ready_x(m_ready_x),
        .s_data_in_y(s_data_in_y), .s_valid_y(s_valid_y), .s_ready_y(s_ready_y),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0, y_acc = 0;
    logic [15:0] x_exp[$];
    logic [15:0] rd_exp[$];
    logic [15:0] xm[16];
    logic [15:0] ym[13];
    logic        rd_chk = 1'b0, rd_pend = 1'b0, hold = 1'b0;
    logic [15:0] held;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(posedge clk) rd_pend <= rd_chk;

    always @(negedge clk) begin
        if (hold && !reset) begin
            chk("x_hold_valid", {31'b0, m_valid_x}, 1);
            chk("x_hold_data", {16'b0, m_data_out_x}, {16'b0, held});
        end
        if (m_valid_x && m_ready_x) begin
            if (x_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL x_extra got %0h expected none", m_data_out_x);
            end else chk("x_data", {16'b0, m_data_out_x}, {16'b0, x_exp.pop_front()});
        end
        if (s_valid_y && s_ready_y) y_acc++;
        if (rd_pend) begin
            if (rd_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_extra got %0h expected none", rd_data);
            end else chk("rd_data", {16'b0, rd_data}, {16'b0, rd_exp.pop_front()});
        end
        hold = m_valid_x && !m_ready_x;
        held = m_data_out_x;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_x;
        for (int i = 0; i < 16; i++) x_exp.push_back(xm[i]);
    endtask

    task automatic send_y(input int base);
        for (int i = 0; i < 13; i++) begin
            s_valid_y   = 1'b1;
            s_data_in_y = 16'(base + i);
            ym[i]       = 16'(base + i);
            tick();
        end
        s_valid_y = 1'b0;
    endtask

    task automatic readback;
        for (int a = 0; a < 13; a++) begin
            rd_addr = 4'(a);
            rd_chk  = 1'b1;
            rd_exp.push_back(ym[a]);
            tick();
        end
        rd_chk = 1'b0;
        tick();
        tick();
        chk("rd_all_seen", rd_exp.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int ybase, ys;
        logic got_done;
        reset = 1'b1; load_en = 1'b0; start = 1'b0; m_ready_x = 1'b0; s_valid_y = 1'b0;
        load_addr = '0; load_data = '0; s_data_in_y = '0; rd_addr = '0;
        tick();
        tick();
        at_neg();
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_valid_x", {31'b0, m_valid_x}, 0);
        chk("rst_ready_y", {31'b0, s_ready_y}, 0);
        chk("rst_rd_data", {16'b0, rd_data}, 0);
        reset = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            xm[i]     = 16'(i + 1);
            load_en   = 1'b1;
            load_addr = 4'(i);
            load_data = 16'(i + 1);
            tick();
        end
        load_en = 1'b0;

        // basic run: x streams back to back, then y
        m_ready_x = 1'b1;
        push_x();
        do_start();
        at_neg();
        chk("t1_busy", {31'b0, busy}, 1);
        chk("t1_valid_x", {31'b0, m_valid_x}, 1);
        chk("t1_ready_y", {31'b0, s_ready_y}, 1);
        chk("t1_done_low", {31'b0, done}, 0);
        repeat (16) tick();
        at_neg();
        chk("t1_valid_x_end", {31'b0, m_valid_x}, 0);
        chk("t1_x_all", x_exp.size(), 0);
        chk("t1_wait_y", {31'b0, done}, 0);
        tick();
        ybase = y_acc;
        send_y(100);
        at_neg();
        chk("t1_done", {31'b0, done}, 1);
        chk("t1_busy_low", {31'b0, busy}, 0);
        chk("t1_y_count", y_acc - ybase, 13);
        tick();
        readback();

        // backpressure plus ignored start/load mid-run
        m_ready_x = 1'b0;
        push_x();
        ybase = y_acc;
        do_start();
        ys = 0;
        got_done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            m_ready_x = c[0];
            start     = (c == 4);
            load_en   = (c == 4);
            load_addr = 4'd3;
            load_data = 16'd999;
            if (ys < 13 && c % 3 != 2) begin
                s_valid_y   = 1'b1;
                s_data_in_y = 16'(300 + ys);
                ym[ys]      = 16'(300 + ys);
                ys++;
            end else s_valid_y = 1'b0;
            tick();
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        start = 1'b0; load_en = 1'b0; s_valid_y = 1'b0; m_ready_x = 1'b0;
        chk("t2_done", {31'b0, got_done}, 1);
        chk("t2_x_all", x_exp.size(), 0);
        chk("t2_y_count", y_acc - ybase, 13);
        readback();

        // concurrent completion; second run also proves xbuf[3] kept its value
        m_ready_x = 1'b1;
        push_x();
        ybase = y_acc;
        do_start();
        repeat (3) tick();
        for (int i = 0; i < 13; i++) begin
            s_valid_y   = 1'b1;
            s_data_in_y = 16'(500 + i);
            ym[i]       = 16'(500 + i);
            if (i == 12) begin
                at_neg();
                chk("t3_busy_before", {31'b0, busy}, 1);
                chk("t3_done_before", {31'b0, done}, 0);
                chk("t3_valid_last", {31'b0, m_valid_x}, 1);
            end
            tick();
        end
        s_valid_y = 1'b0;
        at_neg();
        chk("t3_busy_fall", {31'b0, busy}, 0);
        chk("t3_done_rise", {31'b0, done}, 1);
        chk("t3_x_all", x_exp.size(), 0);
        chk("t3_y_count", y_acc - ybase, 13);
        tick();
        s_valid_y   = 1'b1;
        s_data_in_y = 16'hdead;
        at_neg();
        chk("t4_stray_ready", {31'b0, s_ready_y}, 0);
        tick();
        s_valid_y = 1'b0;
        chk("t4_stray_count", y_acc - ybase, 13);
        readback();

        // reset mid-run
        push_x();
        do_start();
        repeat (5) tick();
        reset = 1'b1;
        #1;
        chk("t5_valid_x", {31'b0, m_valid_x}, 0);
        chk("t5_ready_y", {31'b0, s_ready_y}, 0);
        chk("t5_busy", {31'b0, busy}, 0);
        chk("t5_done", {31'b0, done}, 0);
        chk("t5_x_sent", x_exp.size(), 11);
        x_exp.delete();
        tick();
        reset = 1'b0;
        tick();
        readback();
        push_x();
        do_start();
        at_neg();
        chk("t5_restart_x0", {16'b0, m_data_out_x}, {16'b0, xm[0]});
        tick();
        send_y(400);
        repeat (2) tick();
        at_neg();
        chk("t5_done_after", {31'b0, done}, 1);
        chk("t5_x_all", x_exp.size(), 0);

        // rerun from DONE overwrites ybuf
        tick();
        push_x();
        do_start();
        at_neg();
        chk("t6_done_clear", {31'b0, done}, 0);
        chk("t6_busy", {31'b0, busy}, 1);
        tick();
        send_y(200);
        repeat (2) tick();
        at_neg();
        chk("t6_done", {31'b0, done}, 1);
        chk("t6_x_all", x_exp.size(), 0);
        tick();
        readback();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
